// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues imem word reads and queues returned instructions with their PC for decode.
// Latency: gnt in cycle t, rvalid in t+1, if_valid in t+2 (registered queue, no bypass).
// Backpressure: credits (queued + outstanding + stale) cap requests at DEPTH; a redirect masks req and if_valid.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = CW + 2;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e          state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [UW-1:0]   used;
    logic            grant;
    logic            drop;
    logic            push;
    logic            pop;

    // Credit check and handshake decode; reset gates req so it falls the instant rst drops.
    always_comb begin
        used      = UW'(count_q) + UW'(outst_q) + UW'(discard_q);
        imem_req  = rst && !redirect_valid && (used < UW'(DEPTH));
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;
        drop      = imem_rvalid && (state_q == FLUSH);
        push      = imem_rvalid && (state_q == RUN) && !redirect_valid;
        if_valid  = (count_q != '0) && !redirect_valid;
        pop       = if_valid && if_ready;
        if_instr  = instr_mem_q[head_q];
        if_pc     = pc_mem_q[head_q];
    end

    // Next-state for PCs, credit counters and queue pointers; a redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            outst_d    = '0;
            // Everything still owed by memory becomes stale, less the response landing now.
            discard_d  = discard_q + outst_q - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(1);
            end
            if (drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(1);
                tail_d    = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            outst_d = outst_q + CW'(grant) - CW'(push);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // RUN/FLUSH tracker: FLUSH while stale responses remain to be dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= (discard_d != '0) ? FLUSH : RUN;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage: instruction and its PC written together at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]    <= resp_pc_q;
        end
    end

    // Credits must keep the queue from ever overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && (count_q == CW'(DEPTH))));
        end
    end
endmodule
